stream_det_ctrl: RTL and testbench
==================================

Name: stream_det_ctrl

Overview:
- Sequencer for the serial sequence-detector datapath (mealy/moore detectors with ports flag, in, clock, rst).
- Accepts a parallel word on a start pulse and holds the attached detector in reset while idle.
- Shifts the word out LSB-first, one bit per clock, and samples the detector flag with a configurable latency.
- Reports the match count and per-bit match positions, then pulses done. Replaces hand-written testbench bit-feeding loops.

Parameters:
- SIZE, 24, word length in bits (>=2).
- FLAG_LAT, 1, clocks from a bit being presented to its flag being sampled. 0 for a Mealy-type detector, 1 for Moore-type; legal range 0..3.
- CNT_W, $clog2(SIZE+1), width of match_cnt. Derived; do not override.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a run; sampled only in IDLE.
- data_in  in  SIZE  word to serialise; captured on the accepted start.
- det_flag  in  1  flag output of the attached detector.
- det_in  out  1  serial bit to the detector's in port.
- det_rst  out  1  reset to the detector's rst port.
- ser_valid  out  1  det_in carries a valid data bit.
- busy  out  1  run in progress (SHIFT or DRAIN).
- done  out  1  one-cycle pulse when results are final.
- match_cnt  out  CNT_W  number of sampled flags in the last run.
- match_map  out  SIZE  bit i = flag sampled for data bit i.

Behaviour:
- One clock, clock; reset rst is synchronous and active-high. Every register updates only on the rising edge of clock.
- Reset values: state=IDLE, det_in=0, ser_valid=0, det_rst=1, busy=0, done=0, match_cnt=0, match_map=0, shift register=0, bit counter=0, sample pipe=0.
- rst asserted mid-run aborts immediately to the reset values. No done pulse is issued.
- States: IDLE, SHIFT, DRAIN, DONE. All outputs are registered.
- IDLE:
  - det_rst=1, busy=0, ser_valid=0.
  - On start=1: load data_in into the shift register, clear match_cnt, match_map and the bit counter, then go to SHIFT.
- SHIFT (exactly SIZE cycles):
  - det_rst=0, ser_valid=1, busy=1.
  - det_in = shift register bit 0. The register shifts right each cycle and the counter increments.
  - When the counter reaches SIZE-1: go to DRAIN if FLAG_LAT>0, else to DONE.
- DRAIN (exactly FLAG_LAT cycles):
  - ser_valid=0, det_in=0, det_rst=0, busy=1.
  - Then go to DONE.
- DONE (1 cycle):
  - done=1, busy=0, det_rst=1.
  - Then go to IDLE.
- Timing: with start sampled at edge 0, ser_valid is high from edge 0 to edge SIZE, and done is high between edges SIZE+FLAG_LAT and SIZE+FLAG_LAT+1.
- Flag sampling:
  - A FLAG_LAT-deep pipe carries (ser_valid, bit index).
  - At each edge where the pipe output is valid with index i and det_flag=1: match_cnt increments and match_map[i] is set.
  - For FLAG_LAT=0, sampling happens at the same edge that retires bit i.
  - det_flag is ignored at all other times, including flag activity while det_rst=1.
- match_cnt saturates at SIZE; it cannot exceed SIZE by construction.
- Results hold from DONE until the next accepted start.
- start while busy or in DONE is ignored, not queued. A start held high restarts on the first IDLE cycle after DONE.
- data_in changes after the accepted start have no effect on the run.

Optional Feature:
- Macro: STREAM_DET_MSB_FIRST_EN.
- Defined: SHIFT presents data bit SIZE-1 first, shifting left. match_map index still refers to the data_in bit position, so bit i of the map corresponds to data_in[i].
- Undefined: LSB-first as specified above.

Decomposition:
- Package stream_det_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DRAIN=2'd2, ST_DONE=2'd3.
  - FLAG_LAT_MAX=3.
- One sub-module, flag_sample_pipe:
  - parameterised delay line of (valid, index) with depth FLAG_LAT.
  - depth 0 is a wire-through.
- FSM, shift register and counters stay in stream_det_ctrl.

Test Plan:
- Reset/idle: rst=1 for 2 cycles then idle → det_rst=1, busy=0, done=0, match_cnt=0, det_in=0, ser_valid=0.
- Echo run, FLAG_LAT=0, SIZE=24: bench sets det_flag=det_in combinationally; start with data_in=24'hCD4D54 → det_in sequence = 0,0,1,0,1,0,1,0,1,0,1,1,... (LSB-first); done at edge 24; match_cnt=12; match_map=24'hCD4D54.
- Latency run, FLAG_LAT=1: det_flag = det_in registered by one clock; same data → done at edge 25; match_cnt=12, match_map=24'hCD4D54. Flag pulses while det_rst=1 are not counted.
- Real detectors: attach mealy (FLAG_LAT=0) and moore (FLAG_LAT=1) and feed 24'hCD4D54 → match_map equals the reference-model detection positions for each detector type.
- Control edges: start pulsed at edge 5 of a run → ignored, single done. rst at edge 10 → next cycle busy=0, match_cnt=0, det_rst=1, no done pulse.
- Macro STREAM_DET_MSB_FIRST_EN, data 24'h800001, echo flag → det_in first bit=1, second bit=0; match_cnt=2, match_map=24'h800001.

Source files
------------

// File: rtl/stream_det_pkg.sv
// Shared definitions for the stream detector sequencer:
// FSM state encoding, flag latency limit and a latency clamp helper.
package stream_det_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int FLAG_LAT_MAX = 3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } state_e;

    // Keeps the sample pipe depth inside 0..FLAG_LAT_MAX.
    function automatic int clamp_lat(input int lat);
        if (lat < 0) begin
            return 0;
        end
        if (lat > FLAG_LAT_MAX) begin
            return FLAG_LAT_MAX;
        end
        return lat;
    endfunction

endpackage

// File: rtl/stream_det_ctrl_flag_sample_pipe.sv
// Delay line carrying (valid, bit index) from the serialiser to the
// flag sampler. Ports: clock, rst (sync, active-high), in_valid/in_idx
// in, out_valid/out_idx out. DEPTH=0 is a plain wire-through.
module flag_sample_pipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 5
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clock | rst;
            assign out_valid = in_valid;
            assign out_idx   = in_idx;
        end else begin : g_pipe
            logic [DEPTH-1:0]       vld_q, vld_d;
            logic [DEPTH*IDX_W-1:0] idx_q, idx_d;

            always_comb begin
                vld_d = '0;
                idx_d = '0;
                vld_d[0] = in_valid;
                idx_d[IDX_W-1:0] = in_idx;
                for (int i = 1; i < DEPTH; i++) begin
                    vld_d[i] = vld_q[i-1];
                    idx_d[i*IDX_W +: IDX_W] =
                        idx_q[(i-1)*IDX_W +: IDX_W];
                end
            end

            always_ff @(posedge clock) begin
                if (rst) begin
                    vld_q <= '0;
                    idx_q <= '0;
                end else begin
                    vld_q <= vld_d;
                    idx_q <= idx_d;
                end
            end

            assign out_valid = vld_q[DEPTH-1];
            assign out_idx   = idx_q[(DEPTH-1)*IDX_W +: IDX_W];
        end
    endgenerate

endmodule

// File: rtl/stream_det_ctrl.sv
// Sequencer that serialises a word into a serial sequence detector and
// collects its flag into a match count and per-bit match map.
// Ports: clock, rst (sync, active-high), start, data_in, det_flag in;
// det_in, det_rst, ser_valid, busy, done, match_cnt, match_map out.
// Option: define STREAM_DET_MSB_FIRST_EN to shift MSB-first.
module stream_det_ctrl
    import stream_det_pkg::*;
#(
    parameter int SIZE     = 24,
    parameter int FLAG_LAT = 1,
    parameter int CNT_W    = $clog2(SIZE + 1)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic [SIZE-1:0]  data_in,
    input  logic             det_flag,
    output logic             det_in,
    output logic             det_rst,
    output logic             ser_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic [SIZE-1:0]  match_map
);

    localparam int LAT        = clamp_lat(FLAG_LAT);
    localparam int IDX_W      = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int DRAIN_LAST = (LAT > 0) ? LAT - 1 : 0;

    state_e           state_q, state_d;
    logic [SIZE-1:0]  sreg_q, sreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             det_in_q, det_in_d;
    logic             det_rst_q, det_rst_d;
    logic             ser_valid_q, ser_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [SIZE-1:0]  match_map_q, match_map_d;

    logic             smp_valid;
    logic [IDX_W-1:0] smp_idx;
    logic [IDX_W-1:0] cur_idx;

    // Data-word position of the bit currently on det_in.
    always_comb begin
`ifdef STREAM_DET_MSB_FIRST_EN
        cur_idx = IDX_W'(SIZE - 1) - bit_cnt_q[IDX_W-1:0];
`else
        cur_idx = bit_cnt_q[IDX_W-1:0];
`endif
    end

    flag_sample_pipe #(
        .DEPTH (LAT),
        .IDX_W (IDX_W)
    ) u_pipe (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (ser_valid_q),
        .in_idx    (cur_idx),
        .out_valid (smp_valid),
        .out_idx   (smp_idx)
    );

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bit_cnt_d   = bit_cnt_q;
        det_in_d    = 1'b0;
        match_cnt_d = match_cnt_q;
        match_map_d = match_map_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_SHIFT;
                    bit_cnt_d   = '0;
                    match_cnt_d = '0;
                    match_map_d = '0;
`ifdef STREAM_DET_MSB_FIRST_EN
                    det_in_d = data_in[SIZE-1];
                    sreg_d   = data_in << 1;
`else
                    det_in_d = data_in[0];
                    sreg_d   = data_in >> 1;
`endif
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q == CNT_W'(SIZE - 1)) begin
                    bit_cnt_d = '0;
                    state_d   = (LAT > 0) ? S_DRAIN : S_DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
`ifdef STREAM_DET_MSB_FIRST_EN
                    det_in_d = sreg_q[SIZE-1];
                    sreg_d   = sreg_q << 1;
`else
                    det_in_d = sreg_q[0];
                    sreg_d   = sreg_q >> 1;
`endif
                end
            end
            S_DRAIN: begin
                if (bit_cnt_q == CNT_W'(DRAIN_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase

        // The pipe is never valid in IDLE, so this cannot collide
        // with the clear on an accepted start.
        if (smp_valid && det_flag) begin
            match_map_d[smp_idx] = 1'b1;
            if (match_cnt_q != CNT_W'(SIZE)) begin
                match_cnt_d = match_cnt_q + CNT_W'(1);
            end
        end

        ser_valid_d = (state_d == S_SHIFT);
        busy_d      = (state_d == S_SHIFT) || (state_d == S_DRAIN);
        done_d      = (state_d == S_DONE);
        det_rst_d   = (state_d == S_IDLE) || (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sreg_q      <= '0;
            bit_cnt_q   <= '0;
            det_in_q    <= 1'b0;
            det_rst_q   <= 1'b1;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            match_cnt_q <= '0;
            match_map_q <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bit_cnt_q   <= bit_cnt_d;
            det_in_q    <= det_in_d;
            det_rst_q   <= det_rst_d;
            ser_valid_q <= ser_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            match_cnt_q <= match_cnt_d;
            match_map_q <= match_map_d;
        end
    end

    assign det_in    = det_in_q;
    assign det_rst   = det_rst_q;
    assign ser_valid = ser_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign match_cnt = match_cnt_q;
    assign match_map = match_map_q;

endmodule

// File: tb/tb_stream_det_ctrl.sv
// Bench for stream_det_ctrl: one Mealy-latency and one Moore-latency
// instance driven in parallel, results checked through a scoreboard.
module tb_stream_det_ctrl;

    localparam int SIZE = 24;
    localparam int CW   = $clog2(SIZE + 1);

    typedef struct {
        logic [SIZE-1:0] map;
        int              cnt;
        int              edge_n;
    } exp_t;

    logic            clock = 1'b0;
    logic            rst;
    logic            start;
    logic [SIZE-1:0] data_in;
    logic            force_flag;
    int              mode;

    logic            det_in0, det_rst0, ser_valid0, busy0, done0;
    logic [CW-1:0]   cnt0;
    logic [SIZE-1:0] map0;
    logic            det_in1, det_rst1, ser_valid1, busy1, done1;
    logic [CW-1:0]   cnt1;
    logic [SIZE-1:0] map1;
    logic            flag0, flag1;

    logic [1:0] h0, h1;
    logic       echo1_q, moore1_q, mealy0, mealy1;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t m0, m1;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference "101" overlapping detector, Mealy and Moore flavours.
    always @(posedge clock) begin
        h0 <= det_rst0 ? 2'b00 : {h0[0], det_in0};
        h1 <= det_rst1 ? 2'b00 : {h1[0], det_in1};
        moore1_q <= det_rst1 ? 1'b0 : mealy1;
        echo1_q <= det_in1;
    end
    assign mealy0 = det_in0 & ~h0[0] & h0[1];
    assign mealy1 = det_in1 & ~h1[0] & h1[1];
    assign flag0 = force_flag | ((mode == 0) ? det_in0 : mealy0);
    assign flag1 = force_flag | ((mode == 0) ? echo1_q : moore1_q);

    stream_det_ctrl #(.SIZE(SIZE), .FLAG_LAT(0)) u_dut0 (
        .clock(clock), .rst(rst), .start(start), .data_in(data_in),
        .det_flag(flag0), .det_in(det_in0), .det_rst(det_rst0),
        .ser_valid(ser_valid0), .busy(busy0), .done(done0),
        .match_cnt(cnt0), .match_map(map0)
    );

    stream_det_ctrl #(.SIZE(SIZE), .FLAG_LAT(1)) u_dut1 (
        .clock(clock), .rst(rst), .start(start), .data_in(data_in),
        .det_flag(flag1), .det_in(det_in1), .det_rst(det_rst1),
        .ser_valid(ser_valid1), .busy(busy1), .done(done1),
        .match_cnt(cnt1), .match_map(map1)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int word_idx(input int k);
`ifdef STREAM_DET_MSB_FIRST_EN
        return SIZE - 1 - k;
`else
        return k;
`endif
    endfunction

    function automatic logic ser_bit(input logic [SIZE-1:0] d,
                                     input int k);
        return d[word_idx(k)];
    endfunction

    function automatic logic [SIZE-1:0] det_ref(input logic [SIZE-1:0] d);
        logic [SIZE-1:0] r;
        r = '0;
        for (int k = 2; k < SIZE; k++) begin
            if (ser_bit(d, k) && !ser_bit(d, k - 1) && ser_bit(d, k - 2))
                r[word_idx(k)] = 1'b1;
        end
        return r;
    endfunction

    always @(negedge clock) begin
        if (done0) begin
            check("dut0_done_expected", 64'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                m0 = q0.pop_front();
                check("dut0_match_cnt", 64'(cnt0), 64'(m0.cnt));
                check("dut0_match_map", 64'(map0), 64'(m0.map));
                check("dut0_done_edge", 64'(cyc), 64'(m0.edge_n));
            end
        end
        if (done1) begin
            check("dut1_done_expected", 64'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                m1 = q1.pop_front();
                check("dut1_match_cnt", 64'(cnt1), 64'(m1.cnt));
                check("dut1_match_map", 64'(map1), 64'(m1.map));
                check("dut1_done_edge", 64'(cyc), 64'(m1.edge_n));
            end
        end
    end

    task automatic run(input logic [SIZE-1:0] d, input int glitch_k,
                       input int rst_k);
        exp_t e;
        int   e0;
        bit   rst_pend;
        bit   aborted;
        rst_pend = 1'b0;
        aborted  = 1'b0;
        // Flag noise while the detectors sit in reset.
        force_flag = 1'b1;
        @(negedge clock);
        @(negedge clock);
        force_flag = 1'b0;
        data_in = d;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        data_in = ~d;
        e0 = cyc;
        e.map = (mode == 0) ? d : det_ref(d);
        e.cnt = $countones(e.map);
        e.edge_n = e0 + SIZE;
        q0.push_back(e);
        e.edge_n = e0 + SIZE + 1;
        q1.push_back(e);
        for (int k = 0; k < SIZE; k++) begin
            @(negedge clock);
            if (rst_pend) begin
                check("rst_busy0", 64'(busy0), 0);
                check("rst_busy1", 64'(busy1), 0);
                check("rst_cnt0", 64'(cnt0), 0);
                check("rst_det_rst0", 64'(det_rst0), 1);
                check("rst_det_rst1", 64'(det_rst1), 1);
                check("rst_done0", 64'(done0), 0);
                rst = 1'b0;
                q0.delete();
                q1.delete();
                aborted = 1'b1;
                break;
            end
            check("det_in0", 64'(det_in0), 64'(ser_bit(d, k)));
            check("det_in1", 64'(det_in1), 64'(ser_bit(d, k)));
            check("ser_valid0", 64'(ser_valid0), 1);
            check("busy1", 64'(busy1), 1);
            start = (k + 1 == glitch_k);
            if (k + 1 == rst_k) begin
                rst = 1'b1;
                rst_pend = 1'b1;
            end
        end
        start = 1'b0;
        if (!aborted) begin
            @(negedge clock);
            check("ser_valid_end0", 64'(ser_valid0), 0);
            check("det_in_end0", 64'(det_in0), 0);
        end
        for (int i = 0; i < 10 && (q0.size() + q1.size()) != 0; i++)
            @(negedge clock);
        check("sb_drained", 64'(q0.size() + q1.size()), 0);
        repeat (4) @(negedge clock);
        check("idle_busy0", 64'(busy0), 0);
        check("idle_det_rst1", 64'(det_rst1), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        data_in = '0;
        force_flag = 1'b0;
        mode = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_det_rst0", 64'(det_rst0), 1);
        check("reset_busy0", 64'(busy0), 0);
        check("reset_done0", 64'(done0), 0);
        check("reset_cnt1", 64'(cnt1), 0);
        check("reset_det_in1", 64'(det_in1), 0);
        check("reset_ser_valid1", 64'(ser_valid1), 0);
        rst = 1'b0;
        @(negedge clock);
        check("idle_det_rst0", 64'(det_rst0), 1);
        check("idle_map0", 64'(map0), 0);

        mode = 0;
        run(24'hCD4D54, -1, -1);
        run(24'hFFFFFF, -1, -1);
        run(24'h800001, -1, -1);
        run(24'h000000, -1, -1);
        run(24'hCD4D54, 5, -1);
        run(24'hCD4D54, -1, 10);
        check("post_rst_cnt1", 64'(cnt1), 0);
        for (int r = 0; r < 3; r++)
            run(SIZE'($urandom), -1, -1);

        mode = 1;
        run(24'hCD4D54, -1, -1);
        run(24'h5A5A5A, -1, -1);
        run(SIZE'($urandom), -1, -1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
